data_mem_lsu: RTL

- Data-memory responder for the core's load/store path.
- Accepts one request at a time, carrying address, write enable, sign-extend and bus-size controls, and performs byte-lane alignment.
- Stores are byte-enabled writes; loads are zero- or sign-extended reads.
- Returns a response through a valid/ready handshake. Contains the data RAM array.

---
 rtl/data_mem_lsu.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_lsu.sv
//------------------------------------------------------------------------------
// data_mem_lsu : single-request data-memory responder with byte-lane alignment,
//                byte-enabled stores, sign/zero-extended loads and a valid/ready
//                response.
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module data_mem_lsu #(
   parameter int DEPTH_WORDS = 1024,
   parameter int READ_LAT    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_we,
   input  logic        req_se,
   input  logic [1:0]  req_bs,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] c_lat_m1 = (READ_LAT == 0) ? 4'd0 : 4'(READ_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [3:0]  r_cnt;
   logic [AW-1:0] r_idx;
   logic [1:0]  r_lo, r_bs;
   logic        r_se;
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_err;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic          w_accept, w_req_err, w_wr_en;
   logic [AW-1:0] w_req_idx, w_rd_idx;
   logic [1:0]    w_rd_lo, w_rd_bs;
   logic          w_rd_se;
   logic [3:0]    w_be;
   logic [31:0]   w_wr_data, w_rd_word, w_load_data;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;

   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

   assign w_accept  = (r_state == S_IDLE) && req_valid;
   assign w_req_idx = req_addr[AW+1:2];
   assign w_req_err = (req_bs == 2'b00)
                   || ((req_bs == 2'b10) && req_addr[0])
                   || ((req_bs == 2'b11) && (req_addr[1:0] != 2'b00))
                   || (req_addr[31:2] >= 30'(DEPTH_WORDS));
   assign w_wr_en   = w_accept && req_we && !w_req_err && rst;

   always_comb begin
      w_be      = 4'b0000;
      w_wr_data = req_wdata;
      case (req_bs)
         2'b01: begin
            w_be      = 4'b0001 << req_addr[1:0];
            w_wr_data = {4{req_wdata[7:0]}};
         end
         2'b10: begin
            w_be      = req_addr[1] ? 4'b1100 : 4'b0011;
            w_wr_data = {2{req_wdata[15:0]}};
         end
         2'b11:   w_be = 4'b1111;
         default: w_be = 4'b0000;
      endcase
   end

   // RAM contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) r_mem[w_req_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
         end
      end
   end

   // Zero-latency loads read with the live request; otherwise the captured one.
   assign w_rd_idx  = (r_state == S_IDLE) ? w_req_idx     : r_idx;
   assign w_rd_lo   = (r_state == S_IDLE) ? req_addr[1:0] : r_lo;
   assign w_rd_bs   = (r_state == S_IDLE) ? req_bs        : r_bs;
   assign w_rd_se   = (r_state == S_IDLE) ? req_se        : r_se;
   assign w_rd_word = r_mem[w_rd_idx];
   assign w_byte    = w_rd_word[8*w_rd_lo +: 8];
   assign w_half    = w_rd_lo[1] ? w_rd_word[31:16] : w_rd_word[15:0];

   always_comb begin
      w_load_data = w_rd_word;
      case (w_rd_bs)
         2'b01:   w_load_data = {{24{w_rd_se & w_byte[7]}}, w_byte};
         2'b10:   w_load_data = {{16{w_rd_se & w_half[15]}}, w_half};
         default: w_load_data = w_rd_word;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (w_req_err || req_we || (READ_LAT == 0)) w_state_nxt = S_RESP;
               else                                        w_state_nxt = S_WAIT;
            end
         end
         S_WAIT:  if (r_cnt == 4'd0) w_state_nxt = S_RESP;
         S_RESP:  if (rsp_ready)     w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt       <= 4'd0;
         r_idx       <= '0;
         r_lo        <= 2'b00;
         r_bs        <= 2'b00;
         r_se        <= 1'b0;
         r_rsp_rdata <= 32'd0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_idx       <= w_req_idx;
                  r_lo        <= req_addr[1:0];
                  r_bs        <= req_bs;
                  r_se        <= req_se;
                  r_cnt       <= c_lat_m1;
                  r_rsp_err   <= w_req_err;
                  r_rsp_rdata <= (!w_req_err && !req_we && (READ_LAT == 0)) ? w_load_data : 32'd0;
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd0) r_rsp_rdata <= w_load_data;
               else               r_cnt       <= r_cnt - 4'd1;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_rdata <= 32'd0;
                  r_rsp_err   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
